// File: rtl/matrix_scan_if.sv
// Framebuffer fetch and LED-matrix pad signals between the scan sequencer and its surroundings.
// master = scan sequencer, slave = framebuffer/pad side.
interface matrix_scan_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  logic                      enable;
  logic [$clog2(ROWS)-1:0]   row_addr;
  logic [COLS-1:0]           row_data;
  logic                      frame_start;
  logic                      CCLK;
  logic                      CSDI;
  logic                      RCLK;
  logic                      RSDI;
  logic                      LE;
  logic                      OEB;

  modport master (
    input  enable, row_data,
    output row_addr, frame_start, CCLK, CSDI, RCLK, RSDI, LE, OEB
  );

  modport slave (
    output enable, row_data,
    input  row_addr, frame_start, CCLK, CSDI, RCLK, RSDI, LE, OEB
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Row-by-row scan sequencer for the 16x16 LED matrix: fetch, shift columns, step row, latch, dwell.
// state     | meaning
// IDLE      | blanked, waiting for enable
// FETCH     | cycle 0 drives row_addr, cycle 1 captures row_data
// SHIFT_COL | COLS bits out on CSDI/CCLK, MSB first
// SHIFT_ROW | one RCLK pulse, RSDI=1 only for row 0
// LATCH     | OEB=1, LE pulse, then advance row
// DISPLAY   | OEB=0 for 2**SCREENTIMERWIDTH cycles
module matrix_scan_ctrl #(
  parameter int ROWS             = 16,
  parameter int COLS             = 16,
  parameter int SCREENTIMERWIDTH = 10,
  parameter int CLKDIV           = 2
) (
  input  logic          clk32mhz,
  input  logic          reset,
  matrix_scan_if.master bus
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(COLS);
  localparam int DW = $clog2(CLKDIV + 2);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_COL, SHIFT_ROW, LATCH, DISPLAY
  } state_t;

  state_t                      state;
  logic [RW-1:0]               row;
  logic [RW-1:0]               row_addr_q;
  logic                        frame_start_q;
  logic                        cclk_q;
  logic                        rclk_q;
  logic                        rsdi_q;
  logic                        le_q;
  logic                        oeb_q;
  logic [COLS-1:0]             shreg;
  logic [DW-1:0]               div_cnt;
  logic [BW-1:0]               bit_cnt;
  logic [SCREENTIMERWIDTH-1:0] dwell_cnt;
  logic                        fetch_ph;

  always_ff @(posedge clk32mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
      cclk_q        <= 1'b0;
      rclk_q        <= 1'b0;
      rsdi_q        <= 1'b0;
      le_q          <= 1'b0;
      oeb_q         <= 1'b1;
      shreg         <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      dwell_cnt     <= '0;
      fetch_ph      <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state)
        IDLE: begin
          oeb_q <= 1'b1;
          if (bus.enable) begin
            state         <= FETCH;
            row_addr_q    <= row;
            frame_start_q <= (row == '0);
            fetch_ph      <= 1'b0;
          end
        end
        FETCH: begin
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            shreg   <= bus.row_data;
            cclk_q  <= 1'b0;
            div_cnt <= DW'(CLKDIV - 1);
            bit_cnt <= BW'(COLS - 1);
            state   <= SHIFT_COL;
          end
        end
        SHIFT_COL: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DW'(CLKDIV - 1);
            if (!cclk_q) begin
              cclk_q <= 1'b1;
            end else begin
              // Data only moves on the falling edge so CSDI is settled at every rise.
              cclk_q <= 1'b0;
              shreg  <= {shreg[COLS-2:0], 1'b0};
              if (bit_cnt == '0) begin
                rsdi_q <= (row == '0);
                rclk_q <= 1'b0;
                state  <= SHIFT_ROW;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end
        end
        SHIFT_ROW: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (!rclk_q) begin
            rclk_q  <= 1'b1;
            div_cnt <= DW'(CLKDIV - 1);
          end else begin
            rclk_q  <= 1'b0;
            rsdi_q  <= 1'b0;
            oeb_q   <= 1'b1;
            div_cnt <= DW'(CLKDIV + 1);
            state   <= LATCH;
          end
        end
        LATCH: begin
          // div_cnt runs CLKDIV+1 .. 0; LE is high while it reads CLKDIV .. 1.
          if (div_cnt == '0) begin
            le_q      <= 1'b0;
            oeb_q     <= 1'b0;
            row       <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            dwell_cnt <= '1;
            state     <= DISPLAY;
          end else begin
            div_cnt <= div_cnt - 1'b1;
            le_q    <= (div_cnt >= DW'(2));
          end
        end
        DISPLAY: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else if (bus.enable) begin
            state         <= FETCH;
            row_addr_q    <= row;
            frame_start_q <= (row == '0);
            fetch_ph      <= 1'b0;
          end else begin
            oeb_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.row_addr    = row_addr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.CCLK        = cclk_q;
  assign bus.CSDI        = shreg[COLS-1];
  assign bus.RCLK        = rclk_q;
  assign bus.RSDI        = rsdi_q;
  assign bus.LE          = le_q;
  assign bus.OEB         = oeb_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: expected rows are queued by the stimulus and
// checked by a monitor at each LE pulse; protocol rules are checked every cycle.
module tb_matrix_scan_ctrl;
  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int STW    = 3;
  localparam int CLKDIV = 2;
  // 2 + 2*2*17 + 2 + 2 + 8
  localparam int ROW_PERIOD   = 82;
  localparam int FRAME_PERIOD = 1312;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [3:0]  row;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fb[ROWS];

  matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCREENTIMERWIDTH(STW), .CLKDIV(CLKDIV)
  ) dut (
    .clk32mhz(clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous framebuffer read: data follows row_addr by one cycle.
  always @(posedge clk) bus.row_data <= fb[bus.row_addr];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push_row(input int r);
    exp_t e;
    e.row  = 4'(r);
    e.data = fb[r];
    exp_q.push_back(e);
  endtask

  // Monitor: per-row accumulators, compared against the queue when LE falls.
  logic        p_cclk, p_rclk, p_le, p_csdi, p_rsdi;
  logic [15:0] col_bits;
  int          col_cnt, rclk_cnt, le_len;
  logic        rsdi_cap, fs_seen;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      col_bits = '0; col_cnt = 0; rclk_cnt = 0; le_len = 0;
      rsdi_cap = 1'b0; fs_seen = 1'b0;
    end else begin
      check("clk_excl", int'(bus.CCLK) + int'(bus.RCLK) + int'(bus.LE) > 1, 0);
      if (bus.LE) begin
        check("le_needs_oeb", int'(bus.OEB), 1);
        le_len++;
      end
      if (bus.CCLK && !p_cclk) begin
        check("csdi_stable", int'(bus.CSDI), int'(p_csdi));
        col_bits = {col_bits[14:0], bus.CSDI};
        col_cnt++;
      end
      if (bus.RCLK && !p_rclk) begin
        check("rsdi_stable", int'(bus.RSDI), int'(p_rsdi));
        rsdi_cap = bus.RSDI;
        rclk_cnt++;
      end
      if (bus.frame_start) fs_seen = 1'b1;
      if (!bus.LE && p_le) begin
        check("row_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("row_addr", int'(bus.row_addr), int'(e.row));
          check("col_data", int'(col_bits), int'(e.data));
          check("cclk_edges", col_cnt, COLS);
          check("rclk_edges", rclk_cnt, 1);
          check("rsdi", int'(rsdi_cap), int'(e.row == 4'd0));
          check("frame_start", int'(fs_seen), int'(e.row == 4'd0));
          check("le_len", le_len, CLKDIV);
          check("oeb_after_le", int'(bus.OEB), 1);
        end
        col_bits = '0; col_cnt = 0; rclk_cnt = 0; le_len = 0;
        rsdi_cap = 1'b0; fs_seen = 1'b0;
      end
    end
    p_cclk = bus.CCLK; p_rclk = bus.RCLK; p_le = bus.LE;
    p_csdi = bus.CSDI; p_rsdi = bus.RSDI;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bad;
    fb[0] = 16'hA5C3;
    for (int i = 1; i < ROWS; i++) fb[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
    reset      = 1'b1;
    bus.enable = 1'b1;

    // Reset held with enable high
    repeat (3) @(negedge clk);
    check("rst_oeb", int'(bus.OEB), 1);
    check("rst_cclk", int'(bus.CCLK), 0);
    check("rst_rclk", int'(bus.RCLK), 0);
    check("rst_le", int'(bus.LE), 0);
    check("rst_csdi", int'(bus.CSDI), 0);
    check("rst_rsdi", int'(bus.RSDI), 0);
    check("rst_row_addr", int'(bus.row_addr), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);

    for (int r = 0; r < ROWS; r++) push_row(r);
    reset = 1'b0;
    @(negedge clk);
    check("first_frame_start", int'(bus.frame_start), 1);

    // Full frame: frame_start spacing
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.frame_start && cnt < 3000);
    check("frame_period", cnt, FRAME_PERIOD);
    check("frame1_rows_done", exp_q.size(), 0);

    // Row period from one fetch to the next
    for (int r = 0; r <= 5; r++) push_row(r);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.row_addr != 4'd1 && cnt < 300);
    check("row_period", cnt, ROW_PERIOD);

    // Drop enable during SHIFT_COL of row 5
    cnt = 0;
    while (!(bus.row_addr == 4'd5 && bus.CCLK) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_row5_shift", int'(bus.row_addr == 4'd5 && bus.CCLK), 1);
    bus.enable = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("row5_latched", exp_q.size(), 0);
    cnt = 0;
    while (bus.OEB && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("row5_displayed", int'(bus.OEB), 0);
    cnt = 0;
    while (!bus.OEB && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_blank", int'(bus.OEB), 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bus.OEB || bus.CCLK || bus.RCLK || bus.LE || bus.row_addr != 4'd5) bad++;
    end
    check("idle_quiet_cycles", bad, 0);

    // Re-enable resumes at row 6 without frame_start
    push_row(6);
    bus.enable = 1'b1;
    cnt = 0;
    while (bus.row_addr != 4'd6 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("resume_row_addr", int'(bus.row_addr), 6);
    check("resume_no_frame_start", int'(bus.frame_start), 0);

    // Async reset in the middle of row 7's column shift
    cnt = 0;
    while (!(bus.row_addr == 4'd7 && bus.CCLK) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_row7_shift", int'(bus.row_addr == 4'd7 && bus.CCLK), 1);
    check("row6_latched", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_oeb", int'(bus.OEB), 1);
    check("midrst_cclk", int'(bus.CCLK), 0);
    check("midrst_le", int'(bus.LE), 0);
    check("midrst_row_addr", int'(bus.row_addr), 0);
    repeat (4) @(negedge clk);

    push_row(0);
    push_row(1);
    reset = 1'b0;
    @(negedge clk);
    check("restart_frame_start", int'(bus.frame_start), 1);
    check("restart_row_addr", int'(bus.row_addr), 0);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("restart_rows_done", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
